regime_sequencer: RTL and testbench
===================================

// Module: regime_sequencer
// PURPOSE
// - Host-side initiator for control_path: queues regime commands and drives its on[1:0]/start inputs.
// - Tracks control_path regime/active outputs to detect regime entry and completion.
// - Reports done/err per command. Sits between the host/testbench command source and control_path.
// PARAMETERS
// - DEPTH   4    command FIFO entries (power of 2, >=2)
// - LEN_W   8    width of cmd_len (CNT-mode start-hold cycles)
// - TIMEOUT 255  max cycles waiting for a control_path reaction before err
// PORTS
// - clk         in   1      clock, rising edge
// - rst         in   1      asynchronous, active-low reset
// - cmd_valid   in   1      command offered
// - cmd_ready   out  1      FIFO not full; push on cmd_valid&&cmd_ready
// - cmd_mode    in   2      0=OFF(NOP) 1=ENU 2=CNT 3=UPD
// - cmd_len     in   LEN_W  CNT only: cycles start is held high after CNT entry
// - on          out  2      to control_path.on
// - start       out  1      to control_path.start
// - regime      in   2      from control_path.regime
// - active      in   1      from control_path.active
// - busy        out  1      FSM not IDLE or FIFO non-empty
// - done        out  1      1-cycle pulse: command completed
// - done_mode   out  2      mode of completed command, valid with done
// - err         out  1      sticky timeout error
// - err_clr     in   1      clears err, flushes FIFO, returns to IDLE
// BEHAVIOUR
// - Reset (rst=0, async): FIFO empty, FSM=IDLE, on=0, start=0, done=0, done_mode=0, err=0, counters=0.
// - FIFO: push blocked when full, even if a pop occurs in the same cycle. Push and pop in one cycle are allowed when not full.
// - FIFO wrap-around: pointers modulo DEPTH.
// - FSM states: IDLE, ENTER, RUN, LEAVE, ERR.
// - IDLE: pop the FIFO head when non-empty and regime==0.
//   - mode 0: done pulse next cycle, stay IDLE.
//   - otherwise: go to ENTER. Pop-to-on latency is 1 cycle.
// - ENTER:
//   - on=mode; start=1 for ENU/CNT, 0 for UPD.
//   - When regime==mode: go to RUN; on=0 from that cycle.
// - RUN:
//   - ENU: start=1 until active==1 is sampled, then start=0, go to LEAVE.
//   - CNT: start=1 for exactly cmd_len cycles counted from RUN entry, then start=0, go to LEAVE. cmd_len=0 gives start=0 at RUN entry.
//   - UPD: start=0, go to LEAVE immediately.
// - LEAVE:
//   - on=0, start=0.
//   - When regime==0: done=1 and done_mode=mode for 1 cycle, go to IDLE.
//   - Back-to-back commands: next pop at the earliest on the cycle after done.
// - Timeout:
//   - Counter clears on entry to ENTER, LEAVE, and ENU-RUN; increments each cycle in those states.
//   - Reaching TIMEOUT: err=1, go to ERR. CNT-RUN and UPD-RUN are not timed.
// - ERR:
//   - on=0, start=0, cmd_ready=0, done never asserted.
//   - err_clr=1: err=0, FIFO flushed, go to IDLE next cycle.
//   - err_clr in any other state: ignored.
// - Simultaneous events:
//   - Timeout and the awaited regime in the same cycle: the regime event wins (no err).
//   - done and a new push in the same cycle: both take effect.
// - Reset mid-command: all outputs to reset values immediately; the queued command is lost.
// CONFIGURATION
// - SEQ_TIMEOUT_EN defined: timeout counter and ERR state as above.
// - SEQ_TIMEOUT_EN undefined: no counter. Waits are unbounded, err tied 0, ERR unreachable, err_clr ignored.
// TESTING
// - Reset: rst=0 mid-ENTER -> on=0, start=0, err=0, cmd_ready=1, busy=0 within the same cycle.
// - CNT len=3 vs control_path: regime reaches 2; start high exactly 3 cycles from RUN entry; regime returns to 0 -> done=1, done_mode=2.
// - UPD then ENU queued back-to-back: on=3 until regime==3, then done_mode=3. Next, on=1 and start held until active=1; after it_end, done_mode=1. Exactly 2 done pulses.
// - FIFO full: push 4 commands while regime held at 1 -> cmd_ready=0. 5th push is not accepted; the 4 entries complete in order.
// - Timeout (SEQ_TIMEOUT_EN, TIMEOUT=8): regime stuck at 0 after an ENU pop -> err=1 after 8 cycles, on=0. err_clr -> FIFO empty, IDLE, err=0.
// - NOP: cmd_mode=0 push -> done pulse with done_mode=0, on stays 0, start stays 0.

Source files
------------

// File: rtl/regime_sequencer.sv
// regime_sequencer: host-side command queue and handshake driver for control_path.
// Commands (OFF/ENU/CNT/UPD) are buffered in a small FIFO and played out one at
// a time: request the regime on `on`, run the regime-specific start handshake,
// then wait for control_path to drop back to regime 0 before reporting done.
// Optional feature: define SEQ_TIMEOUT_EN to bound every wait on control_path
// with a TIMEOUT-cycle counter that parks the sequencer in ERR until err_clr.
module regime_sequencer #(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [1:0]       on,
  output logic             start,
  input  logic [1:0]       regime,
  input  logic             active,
  output logic             busy,
  output logic             done,
  output logic [1:0]       done_mode,
  output logic             err,
  input  logic             err_clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = 2 + LEN_W;

  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_ENU = 2'd1;
  localparam logic [1:0] MODE_CNT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTER = 3'd1,
    S_RUN   = 3'd2,
    S_LEAVE = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Command FIFO storage and pointers; pointers wrap naturally (DEPTH is a power of 2).
  logic [ENT_W-1:0] entry_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             fifo_full, fifo_empty;
  logic             push, pop, flush;
  logic [1:0]       head_mode;
  logic [LEN_W-1:0] head_len;

  // Latched command being executed and its CNT start-hold counter.
  logic [1:0]       mode_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W:0]   cnt_reg;

  logic             done_reg, done_next;
  logic [1:0]       done_mode_reg, done_mode_next;
  logic             timeout_hit;

  assign fifo_full  = (count_reg == (PTR_W+1)'(DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign {head_mode, head_len} = entry_reg[rd_ptr_reg];

  // A full FIFO refuses pushes even if a pop frees a slot in the same cycle.
  assign cmd_ready = !fifo_full && (state_reg != S_ERR);
  assign push      = cmd_valid && cmd_ready;
  assign flush     = (state_reg == S_ERR) && err_clr;

  assign busy      = (state_reg != S_IDLE) || !fifo_empty;
  assign done      = done_reg;
  assign done_mode = done_mode_reg;

  // Write the offered command into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_reg[wr_ptr_reg] <= {cmd_mode, cmd_len};
    end
  end

  // FIFO pointer and occupancy bookkeeping; err_clr in ERR discards everything queued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic plus the on/start drive to control_path and the FIFO pop.
  // Awaited regime/active events are tested before the timeout so they win a tie.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    on         = 2'd0;
    start      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // Hold off one cycle after done so the host sees each completion separately.
        if (!fifo_empty && (regime == MODE_OFF) && !done_reg) begin
          pop = 1'b1;
          if (head_mode != MODE_OFF) state_next = S_ENTER;
        end
      end
      S_ENTER: begin
        on    = mode_reg;
        start = (mode_reg == MODE_ENU) || (mode_reg == MODE_CNT);
        if (regime == mode_reg)  state_next = S_RUN;
        else if (timeout_hit)    state_next = S_ERR;
      end
      S_RUN: begin
        case (mode_reg)
          MODE_ENU: begin
            start = 1'b1;
            if (active)           state_next = S_LEAVE;
            else if (timeout_hit) state_next = S_ERR;
          end
          MODE_CNT: begin
            // start stays high for exactly len_reg RUN cycles (none when len_reg is 0).
            start = (cnt_reg < {1'b0, len_reg});
            if ((cnt_reg + 1'b1) >= {1'b0, len_reg}) state_next = S_LEAVE;
          end
          default: begin
            state_next = S_LEAVE;
          end
        endcase
      end
      S_LEAVE: begin
        if (regime == MODE_OFF) state_next = S_IDLE;
        else if (timeout_hit)   state_next = S_ERR;
      end
      S_ERR: begin
        if (err_clr) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Completion is a NOP pop or the return to regime 0 while leaving.
  always_comb begin
    done_next      = (pop && (head_mode == MODE_OFF)) ||
                     ((state_reg == S_LEAVE) && (regime == MODE_OFF));
    done_mode_next = pop ? head_mode : mode_reg;
  end

  // Command latch, CNT run counter and the one-cycle done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_reg      <= MODE_OFF;
      len_reg       <= '0;
      cnt_reg       <= '0;
      done_reg      <= 1'b0;
      done_mode_reg <= 2'd0;
    end else begin
      if (pop) begin
        mode_reg <= head_mode;
        len_reg  <= head_len;
      end
      if (state_reg == S_RUN) cnt_reg <= cnt_reg + 1'b1;
      else                    cnt_reg <= '0;
      done_reg <= done_next;
      if (done_next) done_mode_reg <= done_mode_next;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [TMO_W-1:0] tmo_reg;
  logic             timed;
  logic             err_reg;

  // Only the waits on control_path are timed; CNT/UPD RUN progress on their own.
  assign timed = (state_reg == S_ENTER) || (state_reg == S_LEAVE) ||
                 ((state_reg == S_RUN) && (mode_reg == MODE_ENU));
  assign timeout_hit = timed && (tmo_reg >= TMO_W'(TIMEOUT - 1));
  assign err = err_reg;

  // Restart the wait counter on every state change, count while waiting in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_reg <= '0;
    end else if (timed && (state_next == state_reg)) begin
      tmo_reg <= tmo_reg + 1'b1;
    end else begin
      tmo_reg <= '0;
    end
  end

  // Sticky error: set on entering ERR, cleared only by err_clr while in ERR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg <= 1'b0;
    end else if ((state_reg != S_ERR) && (state_next == S_ERR)) begin
      err_reg <= 1'b1;
    end else if (flush) begin
      err_reg <= 1'b0;
    end
  end
`else
  // Waits on control_path are unbounded; ERR can never be entered.
  localparam int unused_timeout = TIMEOUT;
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_regime_sequencer.sv
// tb_regime_sequencer: directed bench for regime_sequencer with a small
// behavioural control_path responder and a done_mode scoreboard.
`timescale 1ns/1ps
module tb_regime_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_mode = 2'd0;
  logic [7:0] cmd_len = 8'd0;
  logic       err_clr = 1'b0;
  logic [1:0] regime = 2'd0;
  logic       active = 1'b0;
  logic       cmd_ready, start, busy, done, err;
  logic [1:0] on, done_mode;

  int n_checks = 0;
  int n_pass = 0;
  int done_count = 0;
  int n_expected = 0;
  logic [1:0] sb[$];

  // responder controls
  bit         stuck = 1'b0;
  bit         ovr_en = 1'b0;
  logic [1:0] ovr_regime = 2'd0;
  int         ph = 0;
  int         cnt_hi = 0;
  int         last_cnt_hi = -1;

  regime_sequencer #(.DEPTH(4), .LEN_W(8), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_len(cmd_len), .on(on), .start(start),
    .regime(regime), .active(active), .busy(busy), .done(done),
    .done_mode(done_mode), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // control_path responder: enters the requested regime, runs a simple
  // ENU/CNT/UPD handshake and returns to regime 0.
  always @(negedge clk) begin
    if (!rst) begin
      regime = 2'd0; active = 1'b0; ph = 0; cnt_hi = 0;
    end else if (ovr_en) begin
      regime = ovr_regime; active = 1'b0; ph = 0; cnt_hi = 0;
    end else begin
      case (regime)
        2'd0: if (on != 2'd0 && !stuck) begin
          regime = on; ph = 0; cnt_hi = 0;
        end
        2'd1: if (on == 2'd0) begin
          if (!active) begin
            if (start) ph++;
            if (ph == 2) active = 1'b1;
          end else begin
            if (ph == 2) check("enu_start_after_active", start, 0);
            ph++;
            if (ph == 4) begin active = 1'b0; regime = 2'd0; end
          end
        end
        2'd2: if (on == 2'd0) begin
          if (start) cnt_hi++;
          else begin last_cnt_hi = cnt_hi; regime = 2'd0; end
        end
        default: if (on == 2'd0) regime = 2'd0;
      endcase
    end
  end

  // Monitor: every done pulse is matched against the oldest expected mode.
  always @(negedge clk) begin
    if (rst && done) begin
      done_count++;
      $display("done mode=%0d", done_mode);
      check("done_queued", int'(sb.size() != 0), 1);
      if (sb.size() != 0) check("done_mode", done_mode, sb.pop_front());
    end
  end

  task automatic push_cmd(input logic [1:0] m, input logic [7:0] l, input bit exp);
    int n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    check("push_ready", cmd_ready, 1);
    $display("push mode=%0d len=%0d", m, l);
    cmd_valid = 1'b1; cmd_mode = m; cmd_len = l;
    if (exp) begin sb.push_back(m); n_expected++; end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 400) begin @(negedge clk); n++; end
    check("idle_reached", int'(!busy && sb.size() == 0), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_on_nz();
    int n = 0;
    while (on == 2'd0 && n < 100) begin @(negedge clk); n++; end
  endtask

  task automatic wait_on_val(input logic [1:0] v, input string nm);
    int n = 0;
    while (on != v && n < 100) begin @(negedge clk); n++; end
    check(nm, on, v);
  endtask

  initial begin
    int d0;
    int n;
    bit quiet;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_on", on, 0);
    check("rst_start", start, 0);
    check("rst_done", done, 0);
    check("rst_done_mode", done_mode, 0);
    check("rst_err", err, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);

    // NOP: done with mode 0, on/start untouched
    push_cmd(2'd0, 8'd0, 1'b1);
    quiet = 1'b1;
    repeat (4) begin
      if (on != 2'd0 || start) quiet = 1'b0;
      @(negedge clk);
    end
    check("nop_on_start_quiet", quiet, 1);
    wait_idle();

    // CNT len=3: start high exactly 3 RUN cycles
    push_cmd(2'd2, 8'd3, 1'b1);
    wait_idle();
    check("cnt_start_cycles", last_cnt_hi, 3);

    // UPD then ENU back-to-back
    d0 = done_count;
    push_cmd(2'd3, 8'd0, 1'b1);
    push_cmd(2'd1, 8'd0, 1'b1);
    wait_on_nz();
    check("upd_first_on", on, 3);
    wait_on_val(2'd1, "enu_on");
    check("enu_start_in_enter", start, 1);
    wait_idle();
    check("upd_enu_done_pulses", done_count - d0, 2);

    // FIFO full while regime held at 1
    ovr_regime = 2'd1; ovr_en = 1'b1;
    repeat (2) @(negedge clk);
    push_cmd(2'd3, 8'd0, 1'b1);
    push_cmd(2'd2, 8'd1, 1'b1);
    push_cmd(2'd1, 8'd0, 1'b1);
    push_cmd(2'd0, 8'd0, 1'b1);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_busy", busy, 1);
    $display("push mode=2 len=5 (offered while full)");
    cmd_valid = 1'b1; cmd_mode = 2'd2; cmd_len = 8'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("full_still_blocked", cmd_ready, 0);
    ovr_regime = 2'd0;
    repeat (2) @(negedge clk);
    ovr_en = 1'b0;
    wait_idle();

    // Asynchronous reset while in ENTER
    stuck = 1'b1;
    push_cmd(2'd2, 8'd3, 1'b0);
    wait_on_val(2'd2, "rst_mid_enter_on");
    #2 rst = 1'b0;
    #1;
    check("rst_mid_on", on, 0);
    check("rst_mid_start", start, 0);
    check("rst_mid_err", err, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    check("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    stuck = 1'b0;
    @(negedge clk);

`ifdef SEQ_TIMEOUT_EN
    // Timeout: regime stuck at 0 after an ENU pop
    stuck = 1'b1;
    push_cmd(2'd1, 8'd0, 1'b0);
    push_cmd(2'd3, 8'd0, 1'b0);
    wait_on_nz();
    n = 0;
    while (!err && n < 50) begin n++; @(negedge clk); end
    check("tmo_cycles", n, 8);
    check("tmo_err", err, 1);
    check("tmo_on", on, 0);
    check("tmo_start", start, 0);
    check("tmo_cmd_ready", cmd_ready, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_err", err, 0);
    check("clr_busy", busy, 0);
    check("clr_cmd_ready", cmd_ready, 1);
    stuck = 1'b0;
    push_cmd(2'd1, 8'd0, 1'b1);
    wait_idle();
`else
    // No timeout: an unanswered ENU waits indefinitely with err low
    stuck = 1'b1;
    push_cmd(2'd1, 8'd0, 1'b0);
    n = 0;
    repeat (20) @(negedge clk);
    check("notmo_err", err, 0);
    check("notmo_still_on", on, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    stuck = 1'b0;
    @(negedge clk);
`endif

    check("sb_drained", sb.size(), 0);
    check("total_done", done_count, n_expected);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
